// File: rtl/l1a_link_pkg.sv
// ============================================================================
// Module : l1a_link_pkg
// Brief  : Shared codes, frame constants and FSM states for the L1A link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l1a_link_pkg;

  localparam logic [2:0] CODE_L1A    = 3'b000;
  localparam logic [2:0] CODE_DELTA  = 3'b001;
  localparam logic [2:0] CODE_ALIGN  = 3'b010;
  localparam logic [2:0] CODE_L1A_PS = 3'b100;
  localparam logic [2:0] CODE_PL1A   = 3'b110;
  localparam logic [2:0] CODE_RST    = 3'b111;

  localparam int FRAME_LEN         = 4;
  localparam int MIN_STARTUP_ZEROS = 4;

  // Command slots, lowest index = highest priority.
  localparam int NUM_CMDS   = 6;
  localparam int IDX_RST    = 0;
  localparam int IDX_ALIGN  = 1;
  localparam int IDX_DELTA  = 2;
  localparam int IDX_L1A_PS = 3;
  localparam int IDX_L1A    = 4;
  localparam int IDX_PL1A   = 5;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SB      = 3'd2,
    ST_C2      = 3'd3,
    ST_C1      = 3'd4,
    ST_C0      = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  function automatic logic [2:0] idx_to_code(input int idx);
    logic [2:0] c;
    case (idx)
      IDX_RST:    c = CODE_RST;
      IDX_ALIGN:  c = CODE_ALIGN;
      IDX_DELTA:  c = CODE_DELTA;
      IDX_L1A_PS: c = CODE_L1A_PS;
      IDX_L1A:    c = CODE_L1A;
      default:    c = CODE_PL1A;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1a_cmd_arbiter.sv
// ============================================================================
// Module : l1a_cmd_arbiter
// Brief  : Pending flags, drop counting and fixed-priority command select.
//          RST slot exists only when L1A_SERIALIZER_RST_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1a_cmd_arbiter
  import l1a_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_l1a,
  input  logic        req_ps,
  input  logic        req_pl1a,
  input  logic        req_align,
  input  logic        req_delta,
  input  logic        req_rst,
  input  logic        consume,
  output logic        valid,
  output logic [2:0]  code,
  output logic [15:0] drop_cnt
);

  logic [NUM_CMDS-1:0] pend_q, pend_d;
  logic [NUM_CMDS-1:0] req_vec, cand, win, clr, drop;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [2:0]          drop_num;
  logic [16:0]         drop_sum;
  logic                found;

`ifdef L1A_SERIALIZER_RST_EN
  always_comb begin
    req_vec             = '0;
    req_vec[IDX_RST]    = req_rst;
    req_vec[IDX_ALIGN]  = req_align;
    req_vec[IDX_DELTA]  = req_delta;
    req_vec[IDX_L1A_PS] = req_l1a & req_ps;
    req_vec[IDX_L1A]    = req_l1a & ~req_ps;
    req_vec[IDX_PL1A]   = req_pl1a;
  end
`else
  logic unused_req_rst;
  assign unused_req_rst = req_rst;

  always_comb begin
    req_vec             = '0;
    req_vec[IDX_ALIGN]  = req_align;
    req_vec[IDX_DELTA]  = req_delta;
    req_vec[IDX_L1A_PS] = req_l1a & req_ps;
    req_vec[IDX_L1A]    = req_l1a & ~req_ps;
    req_vec[IDX_PL1A]   = req_pl1a;
  end
`endif

  // Same-cycle requests compete directly so an idle line launches immediately.
  always_comb begin
    cand  = pend_q | req_vec;
    win   = '0;
    code  = CODE_L1A;
    found = 1'b0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (cand[i] && !found) begin
        win[i] = 1'b1;
        code   = idx_to_code(i);
        found  = 1'b1;
      end
    end
    valid = found;
  end

  // A consumed pending flag is re-armed by a same-edge request; a winner that
  // came straight from the request line leaves nothing behind.
  always_comb begin
    clr      = consume ? win : '0;
    pend_d   = (pend_q & ~clr) | (req_vec & ~(clr & ~pend_q));
    drop     = req_vec & pend_q & ~clr;
    drop_num = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      drop_num = drop_num + {2'b00, drop[i]};
    end
    drop_sum   = {1'b0, drop_cnt_q} + {14'd0, drop_num};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: rtl/l1a_serializer.sv
// ============================================================================
// Module : l1a_serializer
// Brief  : Single-wire L1A trigger transmitter: startup zero-run, 4-bit frames.
//          Optional remote reset command enabled by L1A_SERIALIZER_RST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1a_serializer
  import l1a_link_pkg::*;
#(
  parameter int STARTUP_ZEROS = 8,
  parameter int GAP           = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_l1a,
  input  logic        req_ps,
  input  logic        req_pl1a,
  input  logic        req_align,
  input  logic        req_delta,
  input  logic        req_rst,
  output logic        tx,
  output logic        busy,
  output logic        sent,
  output logic [2:0]  sent_code,
  output logic [15:0] drop_cnt
);

  localparam int         ZEROS_EFF  = (STARTUP_ZEROS < MIN_STARTUP_ZEROS) ?
                                      MIN_STARTUP_ZEROS : STARTUP_ZEROS;
  localparam logic [7:0] ZEROS_LAST = 8'(ZEROS_EFF - 1);
  localparam logic [7:0] GAP_LAST   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  sent_code_q, sent_code_d;
  logic        tx_q, tx_d;
  logic        sent_q, sent_d;
  logic        consume;
  logic        arb_valid;
  logic [2:0]  arb_code;

  l1a_cmd_arbiter u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req_l1a   (req_l1a),
    .req_ps    (req_ps),
    .req_pl1a  (req_pl1a),
    .req_align (req_align),
    .req_delta (req_delta),
    .req_rst   (req_rst),
    .consume   (consume),
    .valid     (arb_valid),
    .code      (arb_code),
    .drop_cnt  (drop_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == ZEROS_LAST) begin
          cnt_d   = 8'd0;
          state_d = arb_valid ? ST_SB : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IDLE: if (arb_valid) state_d = ST_SB;
      ST_SB:   state_d = ST_C2;
      ST_C2:   state_d = ST_C1;
      ST_C1:   state_d = ST_C0;
      ST_C0: begin
        if (GAP > 0) begin
          state_d = ST_GAP;
          cnt_d   = 8'd0;
        end else begin
          state_d = arb_valid ? ST_SB : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = arb_valid ? ST_SB : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    // The line is registered, so it is driven from the state being entered.
    consume = (state_d == ST_SB);
    code_d  = consume ? arb_code : code_q;
    case (state_d)
      ST_SB:   tx_d = 1'b1;
      ST_C2:   tx_d = code_d[2];
      ST_C1:   tx_d = code_d[1];
      ST_C0:   tx_d = code_d[0];
      default: tx_d = 1'b0;
    endcase
    sent_d      = (state_d == ST_C0);
    sent_code_d = sent_d ? code_q : sent_code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STARTUP;
      cnt_q       <= 8'd0;
      code_q      <= 3'd0;
      tx_q        <= 1'b0;
      sent_q      <= 1'b0;
      sent_code_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      tx_q        <= tx_d;
      sent_q      <= sent_d;
      sent_code_q <= sent_code_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign sent      = sent_q;
  assign sent_code = sent_code_q;

endmodule

`default_nettype wire

// File: tb/tb_l1a_serializer.sv
// ============================================================================
// Module : tb_l1a_serializer
// Brief  : Self-checking bench for l1a_serializer; follows L1A_SERIALIZER_RST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l1a_serializer;
  import l1a_link_pkg::*;

  localparam int STARTUP_ZEROS = 8;
  localparam int GAP           = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_l1a = 1'b0, req_ps = 1'b0, req_pl1a = 1'b0;
  logic        req_align = 1'b0, req_delta = 1'b0, req_rst = 1'b0;
  logic        tx, busy, sent;
  logic [2:0]  sent_code;
  logic [15:0] drop_cnt;

  l1a_serializer #(.STARTUP_ZEROS(STARTUP_ZEROS), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req_l1a(req_l1a), .req_ps(req_ps),
    .req_pl1a(req_pl1a), .req_align(req_align), .req_delta(req_delta),
    .req_rst(req_rst), .tx(tx), .busy(busy), .sent(sent),
    .sent_code(sent_code), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: priority slots 0..5 = RST, ALIGN, DELTA, L1A+PS, L1A, PL1A.
  typedef struct {
    logic       b;
    logic       last;
    logic [2:0] code;
  } slot_t;

  slot_t       line_q[$];
  logic [5:0]  m_pend = '0;
  int          m_startup = 0;
  bit          m_ok = 1'b0;
  logic        e_tx = 1'b0, e_busy = 1'b1, e_sent = 1'b0;
  logic [2:0]  e_code = 3'd0;
  logic [15:0] e_drop = 16'd0;

  function automatic logic [2:0] cmd_code(input int t);
    case (t)
      0:       return 3'b111;
      1:       return 3'b010;
      2:       return 3'b001;
      3:       return 3'b100;
      4:       return 3'b000;
      default: return 3'b110;
    endcase
  endfunction

  initial forever begin
    logic [5:0] r;
    logic [2:0] c;
    slot_t      s;
    int         w;
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_startup = STARTUP_ZEROS; line_q.delete();
      e_tx = 1'b0; e_busy = 1'b1; e_sent = 1'b0; e_code = 3'd0; e_drop = 16'd0;
      m_ok = 1'b1;
    end else begin
      r = '0;
`ifdef L1A_SERIALIZER_RST_EN
      r[0] = req_rst;
`endif
      r[1] = req_align; r[2] = req_delta; r[3] = req_l1a & req_ps;
      r[4] = req_l1a & ~req_ps; r[5] = req_pl1a;
      if (m_startup > 1) begin
        m_startup--;
      end else begin
        m_startup = 0;
        if (line_q.size() == 0 && (m_pend | r) != 6'd0) begin
          w = 0;
          while (!(m_pend[w] | r[w])) w++;
          if (m_pend[w]) m_pend[w] = 1'b0;
          else r[w] = 1'b0;
          c = cmd_code(w);
          for (int k = 0; k < FRAME_LEN; k++) begin
            s.b    = (k == 0) ? 1'b1 : c[FRAME_LEN - 1 - k];
            s.last = (k == FRAME_LEN - 1);
            s.code = c;
            line_q.push_back(s);
          end
          for (int k = 0; k < GAP; k++) begin
            s.b = 1'b0; s.last = 1'b0; s.code = c;
            line_q.push_back(s);
          end
        end
      end
      for (int t = 0; t < 6; t++) begin
        if (r[t]) begin
          if (m_pend[t]) begin
            if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
          end else begin
            m_pend[t] = 1'b1;
          end
        end
      end
      if (line_q.size() > 0) begin
        s = line_q.pop_front();
        e_tx = s.b; e_busy = 1'b1; e_sent = s.last;
        if (s.last) e_code = s.code;
      end else begin
        e_tx = 1'b0; e_busy = (m_startup > 0); e_sent = 1'b0;
      end
    end
  end

  logic       tx_h[$];
  logic       sent_h[$];
  logic [2:0] code_h[$];

  initial forever begin
    @(negedge clk);
    tx_h.push_back(tx); sent_h.push_back(sent); code_h.push_back(sent_code);
    if (m_ok) begin
      check("tx", {31'd0, tx}, {31'd0, e_tx});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("sent", {31'd0, sent}, {31'd0, e_sent});
      check("sent_code", {29'd0, sent_code}, {29'd0, e_code});
      check("drop_cnt", {16'd0, drop_cnt}, {16'd0, e_drop});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_bits(input int start, input int n, input logic [31:0] exp, input string name);
    logic [31:0] act;
    act = '0;
    if (start + n > tx_h.size()) begin
      check({name, "_len"}, tx_h.size(), start + n);
    end else begin
      for (int i = 0; i < n; i++) act = {act[30:0], tx_h[start + i]};
      check(name, act, exp);
    end
  endtask

  task automatic count_startup(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    check(name, n, STARTUP_ZEROS);
  endtask

  int s, r;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check("rst_tx", {31'd0, tx}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_sent", {31'd0, sent}, 0);
    check("rst_sent_code", {29'd0, sent_code}, 0);
    check("rst_drop", {16'd0, drop_cnt}, 0);
    rst = 1'b0;
    count_startup("startup_len");
    repeat (2) step();

    // Prescaled L1A from idle.
    s = tx_h.size();
    req_l1a = 1'b1; req_ps = 1'b1; step();
    req_l1a = 1'b0; req_ps = 1'b0; repeat (5) step();
    expect_bits(s, 4, 32'b1100, "l1a_ps_frame");
    check("l1a_ps_sent_early", {31'd0, sent_h[s + 2]}, 0);
    check("l1a_ps_sent", {31'd0, sent_h[s + 3]}, 1);
    check("l1a_ps_code", {29'd0, code_h[s + 3]}, 32'b100);

    // Three simultaneous requests run back-to-back in priority order.
    s = tx_h.size();
    req_delta = 1'b1; req_align = 1'b1; req_l1a = 1'b1; step();
    req_delta = 1'b0; req_align = 1'b0; req_l1a = 1'b0; repeat (13) step();
    expect_bits(s, 12, 32'b1010_1001_1000, "triple_frames");
    check("triple_code", {29'd0, code_h[s + 11]}, 32'b000);
    check("triple_drop", {16'd0, drop_cnt}, 0);

    // PL1A requested three times while an ALIGN frame is on the line.
    s = tx_h.size();
    req_align = 1'b1; step();
    req_align = 1'b0; req_pl1a = 1'b1; step();
    step();
    step();
    req_pl1a = 1'b0; repeat (6) step();
    expect_bits(s, 8, 32'b1010_1110, "pl1a_after_align");
    check("pl1a_drops", {16'd0, drop_cnt}, 2);

    // Reset while the DELTA frame is on its C1 bit.
    s = tx_h.size();
    req_delta = 1'b1; step();
    req_delta = 1'b0; step();
    step();
    rst = 1'b1; step();
    rst = 1'b0;
    count_startup("restart_len");
    expect_bits(s, 3, 32'b100, "delta_partial");
    expect_bits(s + 3, STARTUP_ZEROS, 32'd0, "restart_zeros");
    check("restart_drop", {16'd0, drop_cnt}, 0);
    s = tx_h.size();
    req_align = 1'b1; step();
    req_align = 1'b0; repeat (5) step();
    expect_bits(s, 4, 32'b1010, "align_after_reset");

    // Request during startup leaves on the last startup edge.
    rst = 1'b1; step();
    r = tx_h.size() - 1;
    rst = 1'b0; req_pl1a = 1'b1; step();
    req_pl1a = 1'b0; repeat (12) step();
    expect_bits(r, 12, 32'b0000_0000_1110, "startup_pending");
    check("startup_pending_drop", {16'd0, drop_cnt}, 0);

    // Remote reset command, twice (second arrives mid-frame).
    s = tx_h.size();
    req_rst = 1'b1; step();
    req_rst = 1'b0; step();
    req_rst = 1'b1; step();
    req_rst = 1'b0; repeat (8) step();
`ifdef L1A_SERIALIZER_RST_EN
    expect_bits(s, 8, 32'b1111_1111, "rst_frames");
`else
    expect_bits(s, 8, 32'd0, "rst_ignored");
`endif
    check("rst_cmd_drop", {16'd0, drop_cnt}, 0);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l1a_serializer.md
# l1a_serializer

Trigger-command transmitter for the single-wire L1A link: it accepts one-cycle command requests from the trigger logic, queues one pending request per command type, arbitrates among them by fixed priority and serialises each as a 4-bit frame on an idle-low line. It is the sending end of the link decoded by `L1A_Discriminator` on the receiving board. It also guarantees the zero-run the receiver needs before it will accept frames after power-up or reset.

## Interface
- `STARTUP_ZEROS`, default 8: zeros driven after reset before the first frame. Legal range 4..255.
- `GAP`, default 0: forced zero cycles after each frame. Legal range 0..15.
- `clk`  in  1  link clock, same clock as the receiver's sampling clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_l1a`  in  1  L1A request, 1-cycle pulse.
- `req_ps`  in  1  prescale qualifier; meaningful only in the same cycle as `req_l1a`.
- `req_pl1a`  in  1  PL1A request.
- `req_align`  in  1  ALIGN request.
- `req_delta`  in  1  DELTA request.
- `req_rst`  in  1  remote-reset request (see Configuration).
- `tx`  out  1  serial line, registered.
- `busy`  out  1  high while a frame or gap is on the line, or during startup.
- `sent`  out  1  1-cycle pulse on the cycle the last code bit is driven.
- `sent_code`  out  3  code of the frame just completed; valid with `sent`.
- `drop_cnt`  out  16  saturating count of dropped requests.

## Operation
- Frame format: start bit `1`, then code bits c2, c1, c0, MSB first. One bit per clock. The line is `0` otherwise.
- Codes: L1A=000, DELTA=001, ALIGN=010, L1A+PS=100, PL1A=110, RST=111. Codes 011 and 101 are never emitted.
- Pending flags: one each for RST, ALIGN, DELTA, L1A, L1A+PS, PL1A.
  - `req_l1a & req_ps` sets L1A+PS. `req_l1a & ~req_ps` sets L1A. `req_ps` alone is ignored.
- Drop rule: a request whose flag is already set and is not being cleared on the same edge increments `drop_cnt`, which saturates at 0xFFFF.
  - A request arriving on the edge its flag is consumed sets the flag again and is not counted as a drop.
  - Several drops in the same cycle count as one increment per dropped type.
- Priority, highest first: RST > ALIGN > DELTA > L1A+PS > L1A > PL1A. Arbitration evaluates the current-cycle requests together with the pending flags, so an idle-line request needs no extra registration cycle.
- FSM states:
  - STARTUP (`tx`=0): counts `STARTUP_ZEROS` cycles, then goes to IDLE.
  - IDLE (`tx`=0): goes to SB if anything is requested or pending.
  - SB (`tx`=1), then C2, C1, C0 (`tx` = the code bit). The winning code is latched and its flag cleared on entry to SB.
  - C0: goes to GAP if `GAP`>0; otherwise to SB if work remains; otherwise to IDLE.
  - GAP (`tx`=0): lasts `GAP` cycles, then goes to SB or IDLE.
- `busy` = state is not IDLE.

## Timing
- Reset values: `tx`=0, `busy`=1 (STARTUP), `sent`=0, `sent_code`=000, `drop_cnt`=0, all flags cleared, state STARTUP.
- Reset asserted mid-frame: `tx`=0 on the next edge, the frame is abandoned and pending flags are cleared. The STARTUP zero-run also flushes the partial frame from the receiver.
- Latency in IDLE: a request sampled at edge n gives `tx`=1 after edge n. Code bits follow after n+1..n+3. `sent` is high after n+3. The receiver pulses its output after edge n+4.
- Frame period is 4+`GAP` cycles. With `GAP`=0, frames run back-to-back with no idle bit; the receiver clears its shift register on decode, so this is legal.
- A request arriving during STARTUP is held pending and sent on the edge that leaves STARTUP.

## Configuration
- `L1A_SERIALIZER_RST_EN` defined: the RST flag exists, `req_rst` has top priority, and code 111 can be emitted.
- Not defined: `req_rst` is ignored (never pending, never counted as a drop) and 111 is never emitted. All other behaviour is identical.

## Structure
- Shared package `l1a_link_pkg` holds:
  - 3-bit code constants (CODE_L1A, CODE_DELTA, CODE_ALIGN, CODE_L1A_PS, CODE_PL1A, CODE_RST);
  - frame length constant (4);
  - FSM state enumeration;
  - minimum startup-zero constant (4).
- One sub-module, `l1a_cmd_arbiter`: pending flags, drop detection and priority select. Outputs are a valid flag and a 3-bit code; the top level drives a consume strobe into it.

## Test plan
- Reset then idle: `tx`=0 for exactly 8 cycles with `busy`=1, then `busy`=0.
- Single `req_l1a` with `req_ps`=1 in IDLE: `tx` = 1,1,0,0; `sent_code`=100; `sent` on the 4th bit.
- `req_delta`, `req_align` and `req_l1a` in the same cycle, `GAP`=0: three back-to-back frames 1010, 1001, 1000 with no zero between them.
- `req_pl1a` pulsed 3 times during one frame: one PL1A frame (1110) follows, `drop_cnt`=2.
- Reset asserted on C1: `tx`=0 next cycle, 8 zeros follow, and a later `req_align` is sent cleanly as 1010.
- `req_rst`: frame 1111 with `L1A_SERIALIZER_RST_EN` defined; line stays 0 and `drop_cnt` unchanged without it.
